wb_write_arbiter: RTL

- Drives the register file's single write port (WE, A3, WD3). It is the initiator end of that interface.
- Merges two write sources:
  - Single-cycle writebacks from the MEM/WB pipeline register, which have absolute priority.
  - Results from a long-latency execution unit (e.g. mul/div), buffered in a small FIFO and drained into idle write-port cycles.
- Keeps a pending-write scoreboard so the hazard unit can stall consumers of registers with results still outstanding.

---
 rtl/wb_write_arbiter_if.sv | 34 +++
 rtl/wb_write_arbiter.sv | 81 ++++++++
 2 files changed

// File: rtl/wb_write_arbiter_if.sv
// Signal bundle between the write-port arbiter and its surroundings: pipeline
// writeback, long-unit result handshake, issue tracking and register-file write port.
interface wb_write_arbiter_if #(
    parameter int CW = 2
) ();
    logic          pipe_valid;
    logic [4:0]    pipe_rd;
    logic [31:0]   pipe_data;
    logic          lu_valid;
    logic [4:0]    lu_rd;
    logic [31:0]   lu_data;
    logic          lu_ready;
    logic          iss_valid;
    logic [4:0]    iss_rd;
    logic          WE;
    logic [4:0]    A3;
    logic [31:0]   WD3;
    logic [31:0]   pend;
    logic [CW-1:0] fifo_count;

    modport master (
        input  pipe_valid, pipe_rd, pipe_data,
        input  lu_valid, lu_rd, lu_data,
        input  iss_valid, iss_rd,
        output lu_ready, WE, A3, WD3, pend, fifo_count
    );

    modport slave (
        output pipe_valid, pipe_rd, pipe_data,
        output lu_valid, lu_rd, lu_data,
        output iss_valid, iss_rd,
        input  lu_ready, WE, A3, WD3, pend, fifo_count
    );
endinterface

// File: rtl/wb_write_arbiter.sv
// Register-file write-port arbiter: pipeline writebacks win, long-unit results
// are buffered and drained into idle cycles; pend tracks outstanding long writes.
module wb_write_arbiter #(
    parameter int DEPTH = 2,
    parameter int CW    = 2
) (
    input  logic                clk,
    input  logic                rst,
    wb_write_arbiter_if.master  bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } lu_entry_t;

    lu_entry_t     fifo [DEPTH];
    lu_entry_t     head;
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count;
    logic [31:0]   pend_q, pend_nxt;
    logic          pipe_hit, nonempty, lu_ready_c, push, pop;

    assign head       = fifo[rd_ptr];
    assign nonempty   = (count != '0);
    assign pipe_hit   = bus.pipe_valid && (bus.pipe_rd != 5'd0);
    // Ready depends only on registered occupancy: a pop this cycle gives no credit.
    assign lu_ready_c = !rst && (count < CW'(DEPTH));
    assign push       = bus.lu_valid && lu_ready_c && (bus.lu_rd != 5'd0);
    assign pop        = !rst && !pipe_hit && nonempty;

    always_comb begin
        bus.WE  = 1'b0;
        bus.A3  = 5'd0;
        bus.WD3 = 32'd0;
        if (!rst) begin
            if (pipe_hit) begin
                bus.WE  = 1'b1;
                bus.A3  = bus.pipe_rd;
                bus.WD3 = bus.pipe_data;
            end else if (nonempty) begin
                bus.WE  = 1'b1;
                bus.A3  = head.rd;
                bus.WD3 = head.data;
            end
        end
    end

    // Issue set is applied after the drain clear so a same-cycle collision stays pending.
    always_comb begin
        pend_nxt = pend_q;
        if (pop)
            pend_nxt[head.rd] = 1'b0;
        if (bus.iss_valid && (bus.iss_rd != 5'd0))
            pend_nxt[bus.iss_rd] = 1'b1;
        pend_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            pend_q <= '0;
        end else begin
            if (push) begin
                fifo[wr_ptr] <= '{rd: bus.lu_rd, data: bus.lu_data};
                wr_ptr       <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count  <= count + CW'(push) - CW'(pop);
            pend_q <= pend_nxt;
        end
    end

    assign bus.lu_ready   = lu_ready_c;
    assign bus.pend       = pend_q;
    assign bus.fifo_count = count;
endmodule
